// File: rtl/timer_display.sv
// timer_display: converts a packed countdown time to BCD and scans it onto an 8-digit 7-segment display.
//   Ports: clk, reset (async, active-low), time_in[26:0] {hr,min,sec,ms}, time_valid,
//          seg[6:0] {g..a} active-low, dp active-low, an[7:0] active-low, busy.
//   Optional macro TIMER_DISPLAY_BLANK_EN: blank zero hr tens digit and all digits until first commit.
module timer_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [26:0] time_in,
    input  logic        time_valid,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        busy
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
`ifdef TIMER_DISPLAY_BLANK_EN
    localparam logic [6:0] SEG_RST = 7'b1111111;
`else
    localparam logic [6:0] SEG_RST = 7'b1000000;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t        state, state_n;
    logic [3:0]    step;
    logic          pend;
    logic [26:0]   pend_data;
    logic [26:0]   src;
    logic          start;
    logic [9:0]    bin [4];
    logic [11:0]   bcd [4];
    logic [3:0]    dig [8];
    logic [3:0]    dig_n [8];
    logic [CW-1:0] rcnt;
    logic [2:0]    idx, idx_n;
    logic [6:0]    seg_n;

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
    function automatic logic [11:0] dabble(input logic [11:0] b, input logic in_bit);
        logic [11:0] t;
        t = b;
        for (int k = 0; k < 3; k++)
            t[k*4 +: 4] = t[k*4 +: 4] >= 4'd5 ? t[k*4 +: 4] + 4'd3 : t[k*4 +: 4];
        return {t[10:0], in_bit};
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'b1000000;
            4'd1:    enc = 7'b1111001;
            4'd2:    enc = 7'b0100100;
            4'd3:    enc = 7'b0110000;
            4'd4:    enc = 7'b0011001;
            4'd5:    enc = 7'b0010010;
            4'd6:    enc = 7'b0000010;
            4'd7:    enc = 7'b1111000;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0010000;
            default: enc = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = time_valid ? SHIFT : IDLE;
            SHIFT:   state_n = step == 4'd9 ? COMMIT : SHIFT;
            COMMIT:  state_n = (pend || time_valid) ? SHIFT : IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy  = state != IDLE;
    assign start = state != SHIFT && state_n == SHIFT;
    // A sample arriving in the COMMIT cycle is newer than the buffered one, so it wins.
    assign src   = (state == IDLE || time_valid) ? time_in : pend_data;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            pend      <= 1'b0;
            pend_data <= '0;
        end else if (state == COMMIT && start) begin
            pend <= 1'b0;
        end else if (busy && time_valid) begin
            pend      <= 1'b1;
            pend_data <= time_in;
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            step <= '0;
            for (int k = 0; k < 4; k++) begin
                bin[k] <= '0;
                bcd[k] <= '0;
            end
        end else if (start) begin
            step   <= '0;
            bin[0] <= {5'd0, src[26:22]};
            bin[1] <= {4'd0, src[21:16]};
            bin[2] <= {4'd0, src[15:10]};
            bin[3] <= src[9:0] > 10'd999 ? 10'd999 : src[9:0];
            for (int k = 0; k < 4; k++) bcd[k] <= '0;
        end else if (state == SHIFT) begin
            step <= step + 4'd1;
            for (int k = 0; k < 4; k++) begin
                bcd[k] <= dabble(bcd[k], bin[k][9]);
                bin[k] <= bin[k] << 1;
            end
        end

    // Digit registers only take the finished conversion, never a partial one.
    always_comb begin
        for (int k = 0; k < 8; k++) dig_n[k] = dig[k];
        if (state == COMMIT) begin
            dig_n[7] = bcd[0][7:4];
            dig_n[6] = bcd[0][3:0];
            dig_n[5] = bcd[1][7:4];
            dig_n[4] = bcd[1][3:0];
            dig_n[3] = bcd[2][7:4];
            dig_n[2] = bcd[2][3:0];
            dig_n[1] = bcd[3][11:8];
            dig_n[0] = bcd[3][7:4];
        end
    end

    assign idx_n = rcnt == LAST ? idx + 3'd1 : idx;

`ifdef TIMER_DISPLAY_BLANK_EN
    logic blank, blank_n;
    assign blank_n = blank && state != COMMIT;
    always_ff @(posedge clk or negedge reset)
        if (!reset) blank <= 1'b1;
        else        blank <= blank_n;
    assign seg_n = (blank_n || (idx_n == 3'd7 && dig_n[7] == 4'd0)) ? 7'b1111111 : enc(dig_n[idx_n]);
`else
    assign seg_n = enc(dig_n[idx_n]);
`endif

    // Outputs are registered from next-state values so an, seg and dp always change together.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rcnt <= '0;
            idx  <= '0;
            an   <= 8'hFE;
            seg  <= SEG_RST;
            dp   <= 1'b1;
            for (int k = 0; k < 8; k++) dig[k] <= '0;
        end else begin
            rcnt <= rcnt == LAST ? '0 : rcnt + 1'b1;
            idx  <= idx_n;
            an   <= ~(8'd1 << idx_n);
            seg  <= seg_n;
            dp   <= !(idx_n == 3'd6 || idx_n == 3'd4 || idx_n == 3'd2);
            dig  <= dig_n;
        end
endmodule
